confreg_sram_slave: RTL and testbench

- Responder end of the uncached sram-like data path: serves requests whose physical address falls in the 0x1faf_xxxx uncached window.
- Holds the board-facing configuration registers: LEDs, numeric display, switch readback and a free-running timer.
- Sits behind the address-translation stage that strips the top 3 bits and flags the access as uncached; decodes only addr[15:0].

---
 rtl/confreg_sram_slave.sv | 256 +++++++++++++++++++++++++
 tb/tb_confreg_sram_slave.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/confreg_sram_slave.sv
// -----------------------------------------------------------------------------
// confreg_sram_slave
//
// Responder end of the uncached sram-like data path. It serves accesses that
// the translation stage has routed into the 0x1faf_xxxx uncached window, and it
// holds the board-facing configuration registers. Only addr[15:0] is decoded.
// addr[1:0] selects byte lanes, and addr[15:2] selects the register.
//
// Register map (word offsets on addr[15:0]):
//   0xf000 LED    RW, low 16 bits (lanes 2-3 do not exist)
//   0xf010 NUM    RW, 32 bits
//   0xf020 SWITCH RO, synchronised switch_in, zero-extended
//   0xe000 TIMER  RW, free-running counter (only with CONFREG_TIMER_EN)
//   other         read 0, writes ignored
//
// Optional feature macro: CONFREG_TIMER_EN
//   defined   -> TIMER register is built
//   undefined -> no timer flops; 0xe000 behaves like an unmapped offset
//
// Handshake (valid/ready): a request is accepted at the rising edge where
// req & addr_ok is 1. The master must hold req and its payload stable until
// that edge. Each accepted request gets exactly one data_ok pulse, LATENCY
// cycles after acceptance. At most one response is ever outstanding. addr_ok
// is high when nothing is pending, or when the pending response is delivered
// in the current cycle. This allows back-to-back acceptance when LATENCY = 1.
//
// Parameters:
//   LATENCY        cycles from acceptance to data_ok (1..7)
//   SW_SYNC_STAGES depth of the switch_in synchroniser (1..3)
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req, wr, size   request valid, write flag, access size (0 B, 1 H, 2/3 W)
//   addr, wdata     physical address, lane-aligned write data
//   addr_ok         request accepted this cycle when req & addr_ok
//   data_ok, rdata  one-cycle response pulse and its read data
//   switch_in       asynchronous board switches
//   led_out         LED register
//   num_out         numeric display register
// -----------------------------------------------------------------------------
module confreg_sram_slave #(
  parameter int LATENCY        = 1,
  parameter int SW_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  localparam logic [15:0] OFF_LED   = 16'hf000;
  localparam logic [15:0] OFF_NUM   = 16'hf010;
  localparam logic [15:0] OFF_SW    = 16'hf020;
`ifdef CONFREG_TIMER_EN
  localparam logic [15:0] OFF_TIMER = 16'he000;
`endif

  // The counter runs 0 .. LATENCY-1 while a response is pending. data_ok
  // fires on the last count.
  localparam logic [2:0] LAST_CNT = 3'(LATENCY - 1);

  // ---------------------------------------------------------------------------
  // Response FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] cnt;
  logic [2:0] cnt_next;
  logic       accept;

  // data_ok and addr_ok come only from registered state. The acceptance
  // decision therefore has no combinational path back through req.
  assign data_ok = (state == S_WAIT) && (cnt == LAST_CNT);
  assign addr_ok = (state == S_IDLE) || data_ok;
  assign accept  = req && addr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        state_next = S_IDLE;
      end
      S_WAIT: begin
        if (cnt == LAST_CNT) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 3'd0;
      end
    endcase
    // A new acceptance restarts the count. This also covers the cycle in
    // which the previous response is being delivered.
    if (accept) begin
      state_next = S_WAIT;
      cnt_next   = 3'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode and byte lanes
  // ---------------------------------------------------------------------------
  logic [15:0] word_off;
  logic [3:0]  byte_en;
  logic        wr_fire;
  logic        unused_addr_hi;

  assign word_off       = {addr[15:2], 2'b00};
  assign wr_fire        = accept && wr;
  assign unused_addr_hi = ^addr[31:16];

  always_comb begin
    byte_en = 4'b1111;
    case (size)
      2'd0:    byte_en = 4'b0001 << addr[1:0];
      2'd1:    byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Replaces the enabled byte lanes of old_val with the matching lanes of
  // wdata.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Switch synchroniser
  // ---------------------------------------------------------------------------
  logic [SW_SYNC_STAGES-1:0][15:0] sw_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync <= '0;
    end else begin
      sw_sync[0] <= switch_in;
      for (int i = 1; i < SW_SYNC_STAGES; i++) begin
        sw_sync[i] <= sw_sync[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic [15:0] led_q;
  logic [31:0] num_q;
  logic [31:0] led_merged;

  // LED has no upper lanes. Writes to lanes 2-3 fall off when the merged
  // word is truncated to 16 bits.
  assign led_merged = merge_lanes({16'h0000, led_q}, wdata, byte_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= 16'hffff;
    end else if (wr_fire && (word_off == OFF_LED)) begin
      led_q <= led_merged[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q <= 32'h0000_0000;
    end else if (wr_fire && (word_off == OFF_NUM)) begin
      num_q <= merge_lanes(num_q, wdata, byte_en);
    end
  end

`ifdef CONFREG_TIMER_EN
  logic [31:0] timer_q;

  // A write takes priority over the increment in its cycle. Lanes that are
  // not written keep their current, un-incremented value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= 32'h0000_0000;
    end else if (wr_fire && (word_off == OFF_TIMER)) begin
      timer_q <= merge_lanes(timer_q, wdata, byte_en);
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end
`endif

  assign led_out = led_q;
  assign num_out = num_q;

  // ---------------------------------------------------------------------------
  // Read path: data is captured at the acceptance edge. Registers therefore
  // show their value from before that edge's update.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_val;
  logic [31:0] rdata_q;

  always_comb begin
    rd_val = 32'h0000_0000;
    case (word_off)
      OFF_LED:   rd_val = {16'h0000, led_q};
      OFF_NUM:   rd_val = num_q;
      OFF_SW:    rd_val = {16'h0000, sw_sync[SW_SYNC_STAGES-1]};
`ifdef CONFREG_TIMER_EN
      OFF_TIMER: rd_val = timer_q;
`endif
      default:   rd_val = 32'h0000_0000;
    endcase
  end

  // rdata holds the last capture. A new acceptance in a data_ok cycle
  // replaces it only at the edge, so the pulse still shows the old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0000_0000;
    end else if (accept) begin
      rdata_q <= wr ? 32'h0000_0000 : rd_val;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_confreg_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_confreg_sram_slave
//
// Two responders share the clock, the reset and switch_in: u_dut_l1
// (LATENCY = 1) and u_dut_l3 (LATENCY = 3). Each has its own master signals.
// A cycle-level reference model, built from the register map and the
// response-timing rules, predicts addr_ok, data_ok, rdata, led_out and
// num_out every cycle.
// -----------------------------------------------------------------------------
module tb_confreg_sram_slave;

  localparam int SYNC = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals (index 0 -> LATENCY 1, index 1 -> LATENCY 3)
  // ---------------------------------------------------------------------------
  logic        req_v   [2];
  logic        wr_v    [2];
  logic [1:0]  size_v  [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        addr_ok_v [2];
  logic        data_ok_v [2];
  logic [31:0] rdata_v   [2];
  logic [15:0] led_v     [2];
  logic [31:0] num_v     [2];
  logic [15:0] switch_in;

  confreg_sram_slave #(.LATENCY(1), .SW_SYNC_STAGES(SYNC)) u_dut_l1 (
    .clk(clk), .rst(rst), .req(req_v[0]), .wr(wr_v[0]), .size(size_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .addr_ok(addr_ok_v[0]),
    .data_ok(data_ok_v[0]), .rdata(rdata_v[0]), .switch_in(switch_in),
    .led_out(led_v[0]), .num_out(num_v[0])
  );

  confreg_sram_slave #(.LATENCY(3), .SW_SYNC_STAGES(SYNC)) u_dut_l3 (
    .clk(clk), .rst(rst), .req(req_v[1]), .wr(wr_v[1]), .size(size_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .addr_ok(addr_ok_v[1]),
    .data_ok(data_ok_v[1]), .rdata(rdata_v[1]), .switch_in(switch_in),
    .led_out(led_v[1]), .num_out(num_v[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / checker
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [15:0] led_m [2];
  logic [31:0] num_m [2];
  logic [31:0] tmr_m [2];
  logic [15:0] sw_hist [3];     // sw_hist[i] = switch_in sampled i+1 edges ago
  // Expected responses per responder: remaining cycles and data. At most one
  // response is outstanding, so each queue holds zero or one entry.
  int          rem_q0[$], rem_q1[$];
  logic [31:0] exp_q0[$], exp_q1[$];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] apply_write(input logic [31:0] old_val, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] mask;
    case (sz)
      2'd0:    mask = 32'h0000_00ff << (8 * a);
      2'd1:    mask = a[1] ? 32'hffff_0000 : 32'h0000_ffff;
      default: mask = 32'hffff_ffff;
    endcase
    return (old_val & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] reg_value(input int k, input logic [15:0] off);
    logic [15:0] w;
    w = {off[15:2], 2'b00};
    if (w == 16'hf000) return {16'h0000, led_m[k]};
    if (w == 16'hf010) return num_m[k];
    if (w == 16'hf020) return {16'h0000, sw_hist[SYNC-1]};
`ifdef CONFREG_TIMER_EN
    if (w == 16'he000) return tmr_m[k];
`endif
    return 32'h0000_0000;
  endfunction

  function automatic bit model_pending(input int k);
    return (k == 0) ? (rem_q0.size() != 0) : (rem_q1.size() != 0);
  endfunction

  function automatic bit model_dok(input int k);
    if (k == 0) return (rem_q0.size() != 0) && (rem_q0[0] == 1);
    return (rem_q1.size() != 0) && (rem_q1[0] == 1);
  endfunction

  function automatic logic [31:0] model_rdata(input int k);
    if (k == 0) return (exp_q0.size() != 0) ? exp_q0[0] : 32'h0;
    return (exp_q1.size() != 0) ? exp_q1[0] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      led_m[k] = 16'hffff;
      num_m[k] = 32'h0;
      tmr_m[k] = 32'h0;
    end
    for (int i = 0; i < 3; i++) sw_hist[i] = 16'h0;
    rem_q0.delete(); rem_q1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  // Advance responder k's model across one rising edge, using the inputs
  // currently driven.
  task automatic model_edge(input int k);
    bit          dok;
    bit          acc;
    logic [15:0] off;
    logic [15:0] w;
    logic [31:0] rv;
    logic [31:0] nv;
    dok = model_dok(k);
    acc = req_v[k] && (!model_pending(k) || dok);
    off = addr_v[k][15:0];
    w   = {off[15:2], 2'b00};
    rv  = reg_value(k, off);
    if (k == 0) begin
      if (rem_q0.size() != 0) begin
        if (dok) begin void'(rem_q0.pop_front()); void'(exp_q0.pop_front()); end
        else rem_q0[0] = rem_q0[0] - 1;
      end
      if (acc) begin rem_q0.push_back(lat_of(k)); exp_q0.push_back(wr_v[k] ? 32'h0 : rv); end
    end else begin
      if (rem_q1.size() != 0) begin
        if (dok) begin void'(rem_q1.pop_front()); void'(exp_q1.pop_front()); end
        else rem_q1[0] = rem_q1[0] - 1;
      end
      if (acc) begin rem_q1.push_back(lat_of(k)); exp_q1.push_back(wr_v[k] ? 32'h0 : rv); end
    end
    if (acc && wr_v[k]) begin
      if (w == 16'hf000) begin
        nv = apply_write({16'h0, led_m[k]}, wdata_v[k], size_v[k], off[1:0]);
        led_m[k] = nv[15:0];
      end
      if (w == 16'hf010) num_m[k] = apply_write(num_m[k], wdata_v[k], size_v[k], off[1:0]);
    end
`ifdef CONFREG_TIMER_EN
    if (acc && wr_v[k] && (w == 16'he000))
      tmr_m[k] = apply_write(tmr_m[k], wdata_v[k], size_v[k], off[1:0]);
    else
      tmr_m[k] = tmr_m[k] + 32'd1;
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at the falling edge)
  // ---------------------------------------------------------------------------
  // Compares this cycle's outputs, then advances the model and the DUT by
  // one clock.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("addr_ok[%0d]", k), addr_ok_v[k], !model_pending(k) || model_dok(k));
      check($sformatf("data_ok[%0d]", k), data_ok_v[k], model_dok(k));
      if (model_dok(k)) check($sformatf("rdata[%0d]", k), rdata_v[k], model_rdata(k));
      check($sformatf("led[%0d]", k), led_v[k], led_m[k]);
      check($sformatf("num[%0d]", k), num_v[k], num_m[k]);
    end
    for (int k = 0; k < 2; k++) model_edge(k);
    sw_hist[2] = sw_hist[1];
    sw_hist[1] = sw_hist[0];
    sw_hist[0] = switch_in;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one request and holds it until it is accepted. waits returns
  // the number of cycles in which it was refused.
  task automatic xfer(input int k, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    req_v[k] = 1'b1; wr_v[k] = w; size_v[k] = sz; addr_v[k] = a; wdata_v[k] = d;
    for (int n = 0; n < 16 && !done; n++) begin
      done = !model_pending(k) || model_dok(k);
      step();
      if (!done) waits++;
    end
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
    req_v[k] = 1'b0;
  endtask

  // After an acceptance from idle, waits for the response and checks it
  // against a fixed expected value.
  task automatic finish_resp(input int k, input string tag, input logic [31:0] exp, input bit is_rd);
    repeat (lat_of(k) - 1) step();
    check({tag, "_dok"}, data_ok_v[k], 1'b1);
    if (is_rd) check(tag, rdata_v[k], exp);
    step();
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_addr_ok[%0d]", k), addr_ok_v[k], 1'b1);
      check($sformatf("rst_data_ok[%0d]", k), data_ok_v[k], 1'b0);
      check($sformatf("rst_rdata[%0d]", k), rdata_v[k], 32'h0);
      check($sformatf("rst_led[%0d]", k), led_v[k], 16'hffff);
      check($sformatf("rst_num[%0d]", k), num_v[k], 32'h0);
    end
  endtask

  task automatic rand_xfer(input int k);
    int          sel;
    int          w;
    logic [15:0] off;
    sel = $urandom_range(0, 4);
    case (sel)
      0:       off = 16'hf000;
      1:       off = 16'hf010;
      2:       off = 16'hf020;
      3:       off = 16'he000;
      default: off = 16'($urandom_range(0, 255) * 4);
    endcase
    off[1:0] = 2'($urandom_range(0, 3));
    switch_in = 16'($urandom);
    xfer(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), {16'h1faf, off}, $urandom, w);
    if ($urandom_range(0, 3) == 0) step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
`ifdef CONFREG_TIMER_EN
  localparam logic [31:0] TMR_EXP = 32'h0000_0002;
`else
  localparam logic [31:0] TMR_EXP = 32'h0000_0000;
`endif

  initial begin
    int w0;
    int w1;
    rst = 1'b1;
    switch_in = 16'h0;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0; wr_v[k] = 1'b0; size_v[k] = 2'd2; addr_v[k] = 32'h0; wdata_v[k] = 32'h0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();

    // LED reads back its reset value.
    xfer(0, 1'b0, 2'd2, 32'h1faf_f000, 32'h0, w0);
    finish_resp(0, "led_rd", 32'h0000_ffff, 1'b1);

    // Word write to NUM, then a byte write into lane 2.
    xfer(0, 1'b1, 2'd2, 32'h1faf_f010, 32'h1234_5678, w0);
    finish_resp(0, "num_wr", 32'h0, 1'b0);
    xfer(0, 1'b1, 2'd0, 32'h1faf_f012, 32'h00ab_0000, w0);
    finish_resp(0, "num_wrb", 32'h0, 1'b0);
    check("num_byte", num_v[0], 32'h12ab_5678);

    // Switch readback through a 2-stage synchroniser.
    switch_in = 16'h00a5;
    repeat (5) step();
    xfer(0, 1'b0, 2'd2, 32'h1faf_f020, 32'h0, w0);
    finish_resp(0, "sw_rd", 32'h0000_00a5, 1'b1);
    switch_in = 16'h005a;
    xfer(0, 1'b0, 2'd2, 32'h1faf_f020, 32'h0, w0);
    finish_resp(0, "sw_rd_old", 32'h0000_00a5, 1'b1);

    // Timer wrap: write, data_ok cycle, 3 idle cycles, then read.
    xfer(0, 1'b1, 2'd2, 32'h1faf_e000, 32'hffff_fffe, w0);
    step();
    repeat (3) step();
    xfer(0, 1'b0, 2'd2, 32'h1faf_e000, 32'h0, w0);
    finish_resp(0, "tmr_rd", TMR_EXP, 1'b1);

    // LATENCY 3: the second request is accepted in the first data_ok cycle.
    xfer(1, 1'b0, 2'd2, 32'h1faf_f000, 32'h0, w0);
    xfer(1, 1'b0, 2'd2, 32'h1faf_f010, 32'h0, w1);
    check("l3_wait0", 32'(w0), 32'd0);
    check("l3_wait1", 32'(w1), 32'd2);
    finish_resp(1, "l3_rd", 32'h0, 1'b1);

    // Randomised traffic on both responders.
    for (int i = 0; i < 150; i++) rand_xfer(0);
    for (int i = 0; i < 100; i++) rand_xfer(1);

    // Reset while a LATENCY 3 response is pending.
    xfer(1, 1'b0, 2'd2, 32'h1faf_f010, 32'h0, w0);
    step();
    #1 rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
